// File: rtl/base_rrmux.sv
// N-way round-robin arbitrating mux with a single registered valid/ready output stage.
// Optional packet lock keeps the grant on one source until it presents end-of-packet.
module base_rrmux #(
    parameter int width = 1,
    parameter int ways  = 2,
    parameter int lock  = 0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [0:ways-1]        i_v,
    output logic [0:ways-1]        i_r,
    input  logic [0:width*ways-1]  i_d,
    input  logic [0:ways-1]        i_e,
    output logic                   o_v,
    input  logic                   o_r,
    output logic [0:width-1]       o_d,
    output logic [0:ways-1]        o_sel,
    output logic                   o_e
);

    // state    | meaning
    // UNLOCKED | any valid way may be granted
    // LOCKED   | only owner_q may be granted until it sends a beat with i_e set

    localparam int PW = (ways > 1) ? $clog2(ways) : 1;

    typedef enum logic {UNLOCKED, LOCKED} lock_state_t;

    lock_state_t     state_q, state_d;
    logic [PW-1:0]   owner_q, owner_d;
    logic [PW-1:0]   ptr, ptr_next, gnt_idx;
    logic [0:ways-1] owner_oh, eligible, grant;
    logic            accept, found, xfer;
    int              idx;

    assign accept = ~o_v | o_r;

    always_comb begin
        owner_oh          = '0;
        owner_oh[owner_q] = 1'b1;
        eligible          = (state_q == LOCKED) ? (i_v & owner_oh) : i_v;
    end

    // First eligible way at or after the pointer, wrapping from ways-1 to 0.
    always_comb begin
        grant   = '0;
        gnt_idx = '0;
        found   = 1'b0;
        idx     = 0;
        for (int i = 0; i < ways; i++) begin
            idx = int'(ptr) + i;
            if (idx >= ways) idx = idx - ways;
            if (!found && eligible[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                gnt_idx    = PW'(idx);
            end
        end
    end

    // o_r reaches i_r combinationally through accept; this path is intentional.
    assign i_r      = accept ? grant : '0;
    assign xfer     = found & accept;
    assign ptr_next = (gnt_idx == PW'(ways - 1)) ? '0 : gnt_idx + 1'b1;

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        if (xfer && (lock != 0)) begin
            if (i_e[gnt_idx]) begin
                state_d = UNLOCKED;
            end else begin
                state_d = LOCKED;
                owner_d = gnt_idx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= UNLOCKED;
            owner_q <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            o_v   <= 1'b0;
            o_d   <= '0;
            o_sel <= '0;
            o_e   <= 1'b0;
            ptr   <= '0;
        end else if (xfer) begin
            o_v   <= 1'b1;
            o_d   <= i_d[int'(gnt_idx)*width +: width];
            o_sel <= grant;
            o_e   <= i_e[gnt_idx] & (lock != 0);
            ptr   <= ptr_next;
        end else if (o_r) begin
            o_v   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_base_rrmux.sv
// Directed bench for base_rrmux: a 4-way unlocked instance and a 2-way packet-lock instance.
module tb_base_rrmux;

    logic        clk;
    logic        a_rst, b_rst;

    logic [0:3]  a_i_v, a_i_r, a_i_e, a_o_sel;
    logic [0:31] a_i_d;
    logic [0:7]  a_o_d;
    logic        a_o_v, a_o_r, a_o_e;

    logic [0:1]  b_i_v, b_i_r, b_i_e, b_o_sel;
    logic [0:15] b_i_d;
    logic [0:7]  b_o_d;
    logic        b_o_v, b_o_r, b_o_e;

    int checks = 0;
    int errors = 0;

    base_rrmux #(.width(8), .ways(4), .lock(0)) dut_a (
        .clk(clk), .reset(a_rst),
        .i_v(a_i_v), .i_r(a_i_r), .i_d(a_i_d), .i_e(a_i_e),
        .o_v(a_o_v), .o_r(a_o_r), .o_d(a_o_d), .o_sel(a_o_sel), .o_e(a_o_e)
    );

    base_rrmux #(.width(8), .ways(2), .lock(1)) dut_b (
        .clk(clk), .reset(b_rst),
        .i_v(b_i_v), .i_r(b_i_r), .i_d(b_i_d), .i_e(b_i_e),
        .o_v(b_o_v), .o_r(b_o_r), .o_d(b_o_d), .o_sel(b_o_sel), .o_e(b_o_e)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock, then check the standing protocol properties on both instances.
    task automatic tick();
        @(posedge clk);
        #1;
        chk("a_ir_onehot0", 32'($onehot0(a_i_r)), 32'd1);
        chk("b_ir_onehot0", 32'($onehot0(b_i_r)), 32'd1);
        if (a_o_v) chk("a_osel_onehot", 32'($onehot(a_o_sel)), 32'd1);
        if (b_o_v) chk("b_osel_onehot", 32'($onehot(b_o_sel)), 32'd1);
    endtask

    logic [0:3] sel;

    initial begin
        a_rst = 1'b1; b_rst = 1'b1;
        a_i_v = '0; a_i_e = '0; a_i_d = '0; a_o_r = 1'b1;
        b_i_v = '0; b_i_e = '0; b_i_d = '0; b_o_r = 1'b1;
        tick();
        tick();
        a_rst = 1'b0; b_rst = 1'b0;

        chk("a_rst_ov", 32'(a_o_v), 32'd0);
        chk("a_rst_osel", 32'(a_o_sel), 32'd0);
        chk("a_rst_oe", 32'(a_o_e), 32'd0);
        chk("b_rst_ov", 32'(b_o_v), 32'd0);

        // Idle for 5 clocks.
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("idle_ov", 32'(a_o_v), 32'd0);
            chk("idle_ir", 32'(a_i_r), 32'd0);
            chk("idle_od", 32'(a_o_d), 32'd0);
        end

        // Fairness: all four ways valid, way j carries 0x10+j.
        a_i_d = {8'h10, 8'h11, 8'h12, 8'h13};
        a_i_v = 4'b1111;
        a_o_r = 1'b1;
        for (int k = 0; k < 5; k++) begin
            sel = 4'b1000 >> (k % 4);
            #1;
            chk("fair_ir", 32'(a_i_r), 32'(sel));
            tick();
            chk("fair_ov", 32'(a_o_v), 32'd1);
            chk("fair_od", 32'(a_o_d), 32'h10 + 32'(k % 4));
            chk("fair_osel", 32'(a_o_sel), 32'(sel));
        end
        a_i_v = 4'b0000;
        tick();
        chk("fair_drain_ov", 32'(a_o_v), 32'd0);

        // Backpressure: way 2 streams A0,A1,A2; o_r low for 3 clocks after the first beat.
        a_i_d = {8'h00, 8'h00, 8'hA0, 8'h00};
        a_i_v = 4'b0010;
        #1;
        chk("bp_ir_first", 32'(a_i_r), 32'(4'b0010));
        tick();
        chk("bp_od_a0", 32'(a_o_d), 32'hA0);
        chk("bp_ov_a0", 32'(a_o_v), 32'd1);
        a_i_d = {8'h00, 8'h00, 8'hA1, 8'h00};
        a_o_r = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("bp_stall_ir", 32'(a_i_r), 32'd0);
            tick();
            chk("bp_stall_od", 32'(a_o_d), 32'hA0);
            chk("bp_stall_ov", 32'(a_o_v), 32'd1);
            chk("bp_stall_osel", 32'(a_o_sel), 32'(4'b0010));
        end
        a_o_r = 1'b1;
        #1;
        chk("bp_resume_ir", 32'(a_i_r), 32'(4'b0010));
        tick();
        chk("bp_od_a1", 32'(a_o_d), 32'hA1);
        a_i_d = {8'h00, 8'h00, 8'hA2, 8'h00};
        tick();
        chk("bp_od_a2", 32'(a_o_d), 32'hA2);
        chk("bp_ov_a2", 32'(a_o_v), 32'd1);
        a_i_v = 4'b0000;
        tick();
        chk("bp_drain_ov", 32'(a_o_v), 32'd0);

        // Wrap and skip: pointer sits at way 3 after the grant to way 2.
        a_i_d = {8'h20, 8'h00, 8'h22, 8'h00};
        a_i_v = 4'b1010;
        #1;
        chk("wrap_ir0", 32'(a_i_r), 32'(4'b1000));
        tick();
        chk("wrap_od0", 32'(a_o_d), 32'h20);
        chk("wrap_osel0", 32'(a_o_sel), 32'(4'b1000));
        chk("wrap_ir2", 32'(a_i_r), 32'(4'b0010));
        tick();
        chk("wrap_od2", 32'(a_o_d), 32'h22);
        chk("wrap_osel2", 32'(a_o_sel), 32'(4'b0010));
        chk("wrap_oe", 32'(a_o_e), 32'd0);
        a_i_v = 4'b0000;
        tick();

        // Packet lock: way 0 sends 30,31,32 (eop on 32); way 1 valid throughout with a one-beat packet.
        b_o_r = 1'b1;
        b_i_v = 2'b11;
        b_i_e = 2'b01;
        b_i_d = {8'h30, 8'h40};
        #1;
        chk("lk_ir_b1", 32'(b_i_r), 32'(2'b10));
        tick();
        chk("lk_od_b1", 32'(b_o_d), 32'h30);
        chk("lk_oe_b1", 32'(b_o_e), 32'd0);
        b_i_d = {8'h31, 8'h40};
        chk("lk_ir_b2", 32'(b_i_r), 32'(2'b10));
        tick();
        chk("lk_od_b2", 32'(b_o_d), 32'h31);
        chk("lk_oe_b2", 32'(b_o_e), 32'd0);
        b_i_d = {8'h32, 8'h40};
        b_i_e = 2'b11;
        chk("lk_ir_b3", 32'(b_i_r), 32'(2'b10));
        tick();
        chk("lk_od_b3", 32'(b_o_d), 32'h32);
        chk("lk_oe_b3", 32'(b_o_e), 32'd1);
        chk("lk_osel_b3", 32'(b_o_sel), 32'(2'b10));
        b_i_v = 2'b01;
        b_i_e = 2'b01;
        chk("lk_ir_w1", 32'(b_i_r), 32'(2'b01));
        tick();
        chk("lk_od_w1", 32'(b_o_d), 32'h40);
        chk("lk_osel_w1", 32'(b_o_sel), 32'(2'b01));
        chk("lk_oe_w1", 32'(b_o_e), 32'd1);
        b_i_v = 2'b00;
        tick();
        chk("lk_drain_ov", 32'(b_o_v), 32'd0);

        // Same packet, reset after beat 2: way 0 abandons it, way 1 wins right after reset.
        b_i_v = 2'b11;
        b_i_e = 2'b01;
        b_i_d = {8'h50, 8'h40};
        #1;
        chk("lr_ir_b1", 32'(b_i_r), 32'(2'b10));
        tick();
        chk("lr_od_b1", 32'(b_o_d), 32'h50);
        b_i_d = {8'h51, 8'h40};
        chk("lr_ir_b2", 32'(b_i_r), 32'(2'b10));
        tick();
        chk("lr_od_b2", 32'(b_o_d), 32'h51);
        b_rst = 1'b1;
        b_i_v = 2'b01;
        tick();
        chk("lr_rst_ov", 32'(b_o_v), 32'd0);
        chk("lr_rst_osel", 32'(b_o_sel), 32'd0);
        b_rst = 1'b0;
        #1;
        chk("lr_ir_w1", 32'(b_i_r), 32'(2'b01));
        tick();
        chk("lr_od_w1", 32'(b_o_d), 32'h40);
        chk("lr_osel_w1", 32'(b_o_sel), 32'(2'b01));
        chk("lr_ov_w1", 32'(b_o_v), 32'd1);
        b_i_v = 2'b00;
        tick();
        chk("lr_drain_ov", 32'(b_o_v), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
